// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned DEF_XLEN = 32;
  localparam int unsigned ENTRY_W  = 2 * DEF_XLEN;

  // A FIFO entry packs {pc, instr}.
  function automatic int unsigned entry_width(int unsigned xlen);
    return 2 * xlen;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO holding {pc, instr} pairs; clear has priority over push/pop.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = ENTRY_W,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_W'(DEPTH));
    do_push = push & ~full & ~clear;
    do_pop  = pop & ~empty & ~clear;
    rdata   = empty ? '0 : mem[rptr];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: one outstanding IMEM request, returned words
// queued with their PC for the IF/ID stage.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = DEF_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_write_o,
  input  logic            flush_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_instr_o
);

  localparam int unsigned EW    = entry_width(XLEN);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_t            state_q;
  state_t            state_d;
  logic              run_q;
  logic [XLEN-1:0]   req_pc_q;
  logic              fire;
  logic              push;
  logic              pop;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic [EW-1:0]     head;

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clear (flush_i),
    .push  (push),
    .pop   (pop),
    .wdata ({req_pc_q, imem_rdata_i}),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (fire) req_pc_q <= pc_i;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fire) state_d = WAIT;
      WAIT: begin
        if (imem_rvalid_i)  state_d = IDLE;
        else if (flush_i)   state_d = DRAIN;
      end
      DRAIN:   if (imem_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address is gated by req so it reads 0 whenever no fetch is being offered.
  always_comb begin
    full        = (count == CNT_W'(DEPTH));
    imem_req_o  = (state_q == IDLE) & run_q & ~flush_i & ~full;
    imem_addr_o = imem_req_o ? pc_i : '0;
    fire        = imem_req_o & imem_gnt_i;
    pc_write_o  = fire | flush_i;
    push        = (state_q == WAIT) & imem_rvalid_i & ~flush_i;
    if_valid_o  = ~empty;
    pop         = if_valid_o & if_ready_i;
    if_pc_o     = head[EW-1:XLEN];
    if_instr_o  = head[XLEN-1:0];
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_ifetch_ctrl;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst_i = 1'b0;
  logic [XLEN-1:0] pc_i;
  logic            pc_write_o;
  logic            flush_i = 1'b0;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i = 1'b0;
  logic            imem_rvalid_i = 1'b0;
  logic [XLEN-1:0] imem_rdata_i = '0;
  logic            if_valid_o;
  logic            if_ready_i = 1'b0;
  logic [XLEN-1:0] if_pc_o;
  logic [XLEN-1:0] if_instr_o;

  always #5 clk = ~clk;

  ifetch_ctrl #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .pc_i          (pc_i),
    .pc_write_o    (pc_write_o),
    .flush_i       (flush_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_ready_i    (if_ready_i),
    .if_pc_o       (if_pc_o),
    .if_instr_o    (if_instr_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: queue of fetched words, an outstanding-request tag
  // (0 none, 1 live, 2 to be discarded) and the PC register it drives.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  bit          m_run = 1'b0;
  int          m_out = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] pc_reg = '0;
  logic [31:0] flush_tgt = '0;

  assign pc_i = pc_reg;

  function automatic bit m_req();
    return m_run && (m_out == 0) && !flush_i && (q.size() < int'(DEPTH));
  endfunction

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      q.delete();
      m_run  <= 1'b0;
      m_out  <= 0;
      pc_reg <= '0;
    end else begin
      m_run <= 1'b1;
      if (m_out == 0 && m_req() && imem_gnt_i) begin
        m_out <= 1;
        m_pc  <= pc_reg;
      end else if (m_out == 1) begin
        if (imem_rvalid_i) m_out <= 0;
        else if (flush_i)  m_out <= 2;
      end else if (m_out == 2 && imem_rvalid_i) begin
        m_out <= 0;
      end
      if ((m_req() && imem_gnt_i) || flush_i)
        pc_reg <= flush_i ? flush_tgt : pc_reg + 32'd4;
      if (flush_i) q.delete();
      else begin
        if (q.size() > 0 && if_ready_i) void'(q.pop_front());
        if (m_out == 1 && imem_rvalid_i) q.push_back({m_pc, imem_rdata_i});
      end
    end
  end

  always @(negedge clk) begin
    #2;
    chk("req",      {31'd0, imem_req_o}, {31'd0, m_req()});
    chk("addr",     imem_addr_o, m_req() ? pc_reg : 32'd0);
    chk("pc_write", {31'd0, pc_write_o}, {31'd0, (m_req() && imem_gnt_i) || flush_i});
    chk("if_valid", {31'd0, if_valid_o}, {31'd0, q.size() > 0});
    chk("if_pc",    if_pc_o,    q.size() > 0 ? q[0].pc    : 32'd0);
    chk("if_instr", if_instr_o, q.size() > 0 ? q[0].instr : 32'd0);
  end

  task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                     input logic fl, input logic [31:0] tgt, input logic rdy);
    @(negedge clk);
    imem_gnt_i    = g;
    imem_rvalid_i = rv;
    imem_rdata_i  = rd;
    flush_i       = fl;
    flush_tgt     = tgt;
    if_ready_i    = rdy;
    #3;
  endtask

  initial begin
    // Reset state
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, if_valid_o}, 32'd0);
    chk("rst_pw", {31'd0, pc_write_o}, 32'd0);
    chk("rst_ifpc", if_pc_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    #3;
    chk("release_req", {31'd0, imem_req_o}, 32'd0);

    // Basic fetch
    cyc(1, 0, 0, 0, 0, 0);
    chk("basic_req", {31'd0, imem_req_o}, 32'd1);
    chk("basic_addr", imem_addr_o, 32'h0);
    chk("basic_pw", {31'd0, pc_write_o}, 32'd1);
    cyc(0, 1, 32'h00500093, 0, 0, 0);
    chk("basic_nobypass", {31'd0, if_valid_o}, 32'd0);
    chk("basic_pw_once", {31'd0, pc_write_o}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("basic_valid", {31'd0, if_valid_o}, 32'd1);
    chk("basic_ifpc", if_pc_o, 32'h0);
    chk("basic_instr", if_instr_o, 32'h00500093);

    // FIFO full stall
    cyc(1, 0, 0, 0, 0, 0);
    chk("stall_addr4", imem_addr_o, 32'h4);
    cyc(0, 1, 32'h0000A013, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      chk("stall_req_full", {31'd0, imem_req_o}, 32'd0);
      chk("stall_pw_full", {31'd0, pc_write_o}, 32'd0);
    end
    cyc(1, 0, 0, 0, 0, 1);
    chk("stall_pop0", if_pc_o, 32'h0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("stall_pop4", if_pc_o, 32'h4);
    chk("stall_pop4_instr", if_instr_o, 32'h0000A013);
    chk("stall_resume", imem_addr_o, 32'h8);

    // Delayed grant at 0x10
    cyc(0, 0, 0, 1, 32'h10, 1);
    chk("redir_pw", {31'd0, pc_write_o}, 32'd1);
    chk("redir_req", {31'd0, imem_req_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 1);
      chk("dly_req", {31'd0, imem_req_o}, 32'd1);
      chk("dly_addr", imem_addr_o, 32'h10);
      chk("dly_pw", {31'd0, pc_write_o}, 32'd0);
    end
    cyc(1, 0, 0, 0, 0, 1);
    chk("dly_gnt_pw", {31'd0, pc_write_o}, 32'd1);
    cyc(0, 1, 32'h11, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("dly_ifpc", if_pc_o, 32'h10);

    // Flush during WAIT
    cyc(0, 0, 0, 1, 32'h20, 1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("fw_addr", imem_addr_o, 32'h20);
    cyc(0, 0, 0, 1, 32'h100, 1);
    chk("fw_pw", {31'd0, pc_write_o}, 32'd1);
    cyc(0, 1, 32'hDEADBEEF, 0, 0, 1);
    chk("fw_drain_req", {31'd0, imem_req_o}, 32'd0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("fw_discard", {31'd0, if_valid_o}, 32'd0);
    chk("fw_target", imem_addr_o, 32'h100);

    // Flush coincident with rvalid and pop, one entry held
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 1, 32'h55, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("fc_head", if_pc_o, 32'h100);
    cyc(0, 1, 32'h66, 1, 32'h200, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("fc_empty", {31'd0, if_valid_o}, 32'd0);
    chk("fc_idle_req", {31'd0, imem_req_o}, 32'd1);
    chk("fc_addr", imem_addr_o, 32'h200);

    // Async reset mid-WAIT, late response after release
    cyc(1, 0, 0, 0, 0, 1);
    @(negedge clk);
    imem_gnt_i = 1'b0;
    #1 rst_i = 1'b0;
    #2;
    chk("ar_req", {31'd0, imem_req_o}, 32'd0);
    chk("ar_pw", {31'd0, pc_write_o}, 32'd0);
    chk("ar_valid", {31'd0, if_valid_o}, 32'd0);
    chk("ar_addr", imem_addr_o, 32'd0);
    cyc(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_i = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hBAD0;
    #3;
    chk("ar_rel_req", {31'd0, imem_req_o}, 32'd0);
    cyc(0, 1, 32'hBAD1, 0, 0, 1);
    chk("ar_first_req", {31'd0, imem_req_o}, 32'd1);
    chk("ar_late_ignored", {31'd0, if_valid_o}, 32'd0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("ar_still_empty", {31'd0, if_valid_o}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        @(negedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
      end else begin
        cyc(1'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 4,
            $urandom,
            $urandom_range(0, 19) == 0,
            $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 9) < 6);
      end
    end

    @(negedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
